// File: rtl/proc_pkg.sv
// Shared pipeline definitions: opcodes, fetch FSM encoding and fetch-packet layout.
package proc_pkg;

  localparam logic [2:0] OP_LDM = 3'b001;
  localparam logic [2:0] OP_STD = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_NOP = 3'b101;

  localparam int FETCH_PKT_W = 64;

  typedef enum logic {
    FETCH     = 1'b0,
    FETCH_IMM = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory read port, pipeline control and IF/ID packet.
interface fetch_stage_if;
  import proc_pkg::*;

  logic [31:0]  imem_addr;
  logic [15:0]  imem_data;
  logic         stall;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         if_valid;
  logic [15:0]  if_instr;
  logic [15:0]  if_imm;
  logic [31:0]  if_pc;
  fetch_state_t dbg_state;

  // Handshake: there is no ready. A packet is consumed on every edge where
  // if_valid=1 and stall=0; while stall=1 the packet and if_valid are held.
  // redirect_valid is a one-cycle pulse that overrides stall.
  modport master (
    output imem_addr, if_valid, if_instr, if_imm, if_pc, dbg_state,
    input  imem_data, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_imm, if_pc, dbg_state,
    output imem_data, stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: packets delivered and stall cycles, both wrapping at 2^32.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pkt_fire,
  input  logic        i_stall,
  output logic [31:0] o_fetched,
  output logic [31:0] o_stall_cycles
);

  logic [31:0] r_fetched;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetched      <= 32'd0;
      r_stall_cycles <= 32'd0;
    end else begin
      if (i_pkt_fire) r_fetched      <= r_fetched + 32'd1;
      if (i_stall)    r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_fetched      = r_fetched;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and merges LDM + immediate word into one packet.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall_cycles counters.
module fetch_stage
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd32,
  parameter logic [2:0]  IMM_OPCODE = OP_LDM
) (
  input  logic         clk,
  input  logic         reset,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall_cycles
`endif
);

  logic [31:0]  r_pc;
  fetch_state_t r_state;
  logic [15:0]  r_lat_instr;
  logic [31:0]  r_lat_pc;
  logic         r_valid;
  fetch_pkt_t   r_pkt;

  logic [31:0]  w_pc_next;
  logic         w_is_imm;
  logic         w_advance;
  logic         w_pkt_fire;

  assign w_pc_next  = r_pc + 32'd1;
  assign w_is_imm   = (bus.imem_data[15:13] == IMM_OPCODE);
  assign w_advance  = !reset && !bus.redirect_valid && !bus.stall;
  assign w_pkt_fire = w_advance && ((r_state == FETCH_IMM) || !w_is_imm);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_state     <= FETCH;
      r_lat_instr <= 16'h0000;
      r_lat_pc    <= 32'd0;
      r_valid     <= 1'b0;
      r_pkt       <= '0;
    end else if (bus.redirect_valid) begin
      // Any half-assembled immediate instruction is dropped here.
      r_pc    <= bus.redirect_pc;
      r_state <= FETCH;
      r_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc <= w_pc_next;
      case (r_state)
        FETCH: begin
          if (w_is_imm) begin
            r_lat_instr <= bus.imem_data;
            r_lat_pc    <= r_pc;
            r_valid     <= 1'b0;
            r_state     <= FETCH_IMM;
          end else begin
            r_pkt   <= '{instr: bus.imem_data, imm: 16'h0000, pc: r_pc};
            r_valid <= 1'b1;
          end
        end
        FETCH_IMM: begin
          r_pkt   <= '{instr: r_lat_instr, imm: bus.imem_data, pc: r_lat_pc};
          r_valid <= 1'b1;
          r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = r_valid;
  assign bus.if_instr  = r_pkt.instr;
  assign bus.if_imm    = r_pkt.imm;
  assign bus.if_pc     = r_pkt.pc;
  assign bus.dbg_state = r_state;

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .clk            (clk),
    .reset          (reset),
    .i_pkt_fire     (w_pkt_fire),
    .i_stall        (bus.stall),
    .o_fetched      (perf_fetched),
    .o_stall_cycles (perf_stall_cycles)
  );
`else
  logic w_unused;
  assign w_unused = w_pkt_fire;
`endif

endmodule
